// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

  // The hard-wired zero register is the top index of the file.
  function automatic int zero_reg(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the register file: writeback, issue, read ports.
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREAD  = 2
);

  logic                          RegWrite;
  logic [ADDR_W-1:0]             WriteRegister;
  logic [DATA_W-1:0]             WriteData;
  logic                          Issue;
  logic [ADDR_W-1:0]             IssueRegister;
  logic [NREAD-1:0][ADDR_W-1:0]  ReadRegister;
  logic [NREAD-1:0][DATA_W-1:0]  ReadData;
  logic [NREAD-1:0]              Busy;

  modport master (
    output RegWrite, WriteRegister, WriteData,
    output Issue, IssueRegister, ReadRegister,
    input  ReadData, Busy
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData,
    input  Issue, IssueRegister, ReadRegister,
    output ReadData, Busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-producer bit per register with per-port lookup.
// The zero register owns no pending flop; its lookup is a constant 0.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREAD  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         set_en,
  input  logic [ADDR_W-1:0]            set_idx,
  input  logic                         clr_en,
  input  logic [ADDR_W-1:0]            clr_idx,
  input  logic [NREAD-1:0][ADDR_W-1:0] rd_idx,
  output logic [NREAD-1:0]             busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NPHYS = zero_reg(ADDR_W);

  logic [NPHYS-1:0] pend_q;
  logic [NPHYS-1:0] pend_d;
  logic [DEPTH-1:0] pend_full;

  // Clear from writeback first, then set from issue so a new producer wins.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NPHYS; i++) begin
      if (clr_en && clr_idx == ADDR_W'(i)) pend_d[i] = 1'b0;
      if (set_en && set_idx == ADDR_W'(i)) pend_d[i] = 1'b1;
    end
  end

  // Pending register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign pend_full = {1'b0, pend_q};

  // Per-port lookup of the registered pending state.
  always_comb begin
    busy = '0;
    for (int p = 0; p < NREAD; p++) busy[p] = pend_full[rd_idx[p]];
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with NREAD combinational read ports, one write port,
// a hard-wired zero register at the top index and a pending scoreboard.
// Build option: REGFILE_SB_BYPASS_EN adds write-through of the current
// writeback to matching read ports (data and Busy).
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREAD  = 2
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam int                NPHYS    = zero_reg(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(zero_reg(ADDR_W));

  logic [DATA_W-1:0] mem  [NPHYS];
  logic [DATA_W-1:0] view [DEPTH];
  logic [NREAD-1:0]  sb_busy;
  logic              wr_en;

  assign wr_en = bus.RegWrite && (bus.WriteRegister != ZERO_IDX);

  // Physical storage; the zero register has no entry here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NPHYS; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NPHYS; i++) begin
        if (wr_en && bus.WriteRegister == ADDR_W'(i)) mem[i] <= bus.WriteData;
      end
    end
  end

  // Full-depth read view with the zero register tied off.
  for (genvar i = 0; i < NPHYS; i++) begin : g_view
    assign view[i] = mem[i];
  end
  assign view[DEPTH-1] = '0;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREAD  (NREAD)
  ) u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (bus.Issue),
    .set_idx (bus.IssueRegister),
    .clr_en  (bus.RegWrite),
    .clr_idx (bus.WriteRegister),
    .rd_idx  (bus.ReadRegister),
    .busy    (sb_busy)
  );

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign idx = bus.ReadRegister[p];

    // Port read: registered view, optional write-through, forced 0 in reset.
    always_comb begin
      data = view[idx];
      busy = sb_busy[p];
`ifdef REGFILE_SB_BYPASS_EN
      if (wr_en && bus.WriteRegister == idx) begin
        data = bus.WriteData;
        // A same-cycle reissue keeps the register busy; report the old pend.
        busy = (bus.Issue && bus.IssueRegister == idx) ? sb_busy[p] : 1'b0;
      end
`else
      // Registered view only; decode waits one more cycle after writeback.
`endif
      if (!reset) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign bus.ReadData[p] = data;
    assign bus.Busy[p]     = busy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  import regfile_sb_pkg::*;

`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(64), .ADDR_W(5), .NREAD(2)) bus_a ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(4), .NREAD(3)) bus_b ();

  regfile_sb #(.DATA_W(64), .ADDR_W(5), .NREAD(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(4), .NREAD(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rw;
    logic [4:0]  wreg;
    logic [63:0] wdata;
    logic        iss;
    logic [4:0]  ireg;
    logic [4:0]  r0, r1;
    logic [63:0] d0, d1;
    logic        b0, b1;
  } vec_t;

  typedef struct {
    logic [63:0] d0, d1;
    logic        b0, b1;
    int          id;
  } exp_t;

  localparam int NVEC = 14;
  localparam logic [63:0] D7 = 64'h1234_5678_9ABC_DEF0;

  vec_t vecs [NVEC];
  exp_t exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_strobes();
    bus_a.RegWrite = 1'b0; bus_a.Issue = 1'b0;
    bus_b.RegWrite = 1'b0; bus_b.Issue = 1'b0;
  endtask

  task automatic step_a(input logic rw, input logic [4:0] wreg, input logic [63:0] wd,
                        input logic iss, input logic [4:0] ireg);
    @(negedge clk);
    bus_a.RegWrite = rw; bus_a.WriteRegister = wreg; bus_a.WriteData = wd;
    bus_a.Issue = iss;   bus_a.IssueRegister = ireg;
    @(posedge clk); #1;
    idle_strobes();
    #1;
  endtask

  task automatic step_b(input logic rw, input logic [3:0] wreg, input logic [31:0] wd,
                        input logic iss, input logic [3:0] ireg);
    @(negedge clk);
    bus_b.RegWrite = rw; bus_b.WriteRegister = wreg; bus_b.WriteData = wd;
    bus_b.Issue = iss;   bus_b.IssueRegister = ireg;
    @(posedge clk); #1;
    idle_strobes();
    #1;
  endtask

  initial begin
    exp_t e;

    //            rw wreg   wdata                 iss ireg  r0     r1     d0                    d1                    b0 b1
    vecs[0]  = '{1, 5'd7,  D7,                   0, 5'd0,  5'd7,  5'd7,  D7,                   D7,                   0, 0};
    vecs[1]  = '{1, 5'd31, 64'hFF,               0, 5'd0,  5'd31, 5'd7,  64'h0,                D7,                   0, 0};
    vecs[2]  = '{0, 5'd0,  64'h0,                1, 5'd5,  5'd5,  5'd31, 64'h0,                64'h0,                1, 0};
    vecs[3]  = '{0, 5'd0,  64'h0,                0, 5'd0,  5'd5,  5'd5,  64'h0,                64'h0,                1, 1};
    vecs[4]  = '{0, 5'd0,  64'h0,                0, 5'd0,  5'd5,  5'd7,  64'h0,                D7,                   1, 0};
    vecs[5]  = '{1, 5'd5,  64'h55,               0, 5'd0,  5'd5,  5'd7,  64'h55,               D7,                   0, 0};
    vecs[6]  = '{1, 5'd9,  64'h99,               1, 5'd9,  5'd9,  5'd9,  64'h99,               64'h99,               1, 1};
    vecs[7]  = '{0, 5'd0,  64'h0,                1, 5'd31, 5'd31, 5'd9,  64'h0,                64'h99,               0, 1};
    vecs[8]  = '{1, 5'd9,  64'h9A,               0, 5'd0,  5'd9,  5'd5,  64'h9A,               64'h55,               0, 0};
    vecs[9]  = '{1, 5'd10, 64'hAB,               1, 5'd11, 5'd10, 5'd11, 64'hAB,               64'h0,                0, 1};
    vecs[10] = '{1, 5'd11, 64'hCD,               1, 5'd10, 5'd10, 5'd11, 64'hAB,               64'hCD,               1, 0};
    vecs[11] = '{1, 5'd12, 64'h12,               0, 5'd0,  5'd12, 5'd10, 64'h12,               64'hAB,               0, 1};
    vecs[12] = '{1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 0, 5'd0, 5'd0, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,             0, 0};
    vecs[13] = '{1, 5'd30, 64'h3030,             0, 5'd0,  5'd30, 5'd0,  64'h3030,             64'hFFFF_FFFF_FFFF_FFFF, 0, 0};

    bus_a.WriteRegister = '0; bus_a.WriteData = '0; bus_a.IssueRegister = '0;
    bus_a.ReadRegister  = '0;
    bus_b.WriteRegister = '0; bus_b.WriteData = '0; bus_b.IssueRegister = '0;
    bus_b.ReadRegister  = '0;
    idle_strobes();

    // Power-up reset.
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Put state in reg 3 / reg 4, then reset over a write+issue.
    bus_a.ReadRegister[0] = 5'd3;
    bus_a.ReadRegister[1] = 5'd4;
    step_a(1'b1, 5'd3, 64'h11, 1'b1, 5'd4);
    check("pre-reset data r3", bus_a.ReadData[0], 64'h11);
    check("pre-reset busy r4", {63'b0, bus_a.Busy[1]}, 64'h1);

    @(negedge clk);
    reset = 1'b0;
    bus_a.RegWrite = 1'b1; bus_a.WriteRegister = 5'd3; bus_a.WriteData = 64'hAA;
    bus_a.Issue    = 1'b1; bus_a.IssueRegister = 5'd4;
    #1;
    check("in-reset data r3", bus_a.ReadData[0], 64'h0);
    check("in-reset busy r4", {63'b0, bus_a.Busy[1]}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle_strobes();
    #1;
    check("post-reset data r3", bus_a.ReadData[0], 64'h0);
    check("post-reset busy r4", {63'b0, bus_a.Busy[1]}, 64'h0);

    // Table-driven write/issue/read sequence, results checked after the edge.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      bus_a.RegWrite = vecs[i].rw;  bus_a.WriteRegister = vecs[i].wreg;
      bus_a.WriteData = vecs[i].wdata;
      bus_a.Issue = vecs[i].iss;    bus_a.IssueRegister = vecs[i].ireg;
      bus_a.ReadRegister[0] = vecs[i].r0;
      bus_a.ReadRegister[1] = vecs[i].r1;
      exp_q.push_back('{vecs[i].d0, vecs[i].d1, vecs[i].b0, vecs[i].b1, i});
      @(posedge clk); #1;
      idle_strobes();
      #1;
      e = exp_q.pop_front();
      check($sformatf("vec%0d data0", e.id), bus_a.ReadData[0], e.d0);
      check($sformatf("vec%0d data1", e.id), bus_a.ReadData[1], e.d1);
      check($sformatf("vec%0d busy0", e.id), {63'b0, bus_a.Busy[0]}, {63'b0, e.b0});
      check($sformatf("vec%0d busy1", e.id), {63'b0, bus_a.Busy[1]}, {63'b0, e.b1});
    end

    // Same-cycle writeback visibility on port 0.
    bus_a.ReadRegister[0] = 5'd2;
    bus_a.ReadRegister[1] = 5'd7;
    step_a(1'b0, 5'd0, 64'h0, 1'b1, 5'd2);
    check("byp pend busy", {63'b0, bus_a.Busy[0]}, 64'h1);

    @(negedge clk);
    bus_a.RegWrite = 1'b1; bus_a.WriteRegister = 5'd2; bus_a.WriteData = 64'h77;
    #1;
    check("byp wr-cycle data", bus_a.ReadData[0], BYP ? 64'h77 : 64'h0);
    check("byp wr-cycle busy", {63'b0, bus_a.Busy[0]}, BYP ? 64'h0 : 64'h1);
    check("byp other port", bus_a.ReadData[1], D7);
    @(posedge clk); #1;
    idle_strobes();
    #1;
    check("byp after data", bus_a.ReadData[0], 64'h77);
    check("byp after busy", {63'b0, bus_a.Busy[0]}, 64'h0);

    step_a(1'b0, 5'd0, 64'h0, 1'b1, 5'd2);
    @(negedge clk);
    bus_a.RegWrite = 1'b1; bus_a.WriteRegister = 5'd2; bus_a.WriteData = 64'h78;
    bus_a.Issue    = 1'b1; bus_a.IssueRegister = 5'd2;
    #1;
    check("reissue wr-cycle data", bus_a.ReadData[0], BYP ? 64'h78 : 64'h77);
    check("reissue wr-cycle busy", {63'b0, bus_a.Busy[0]}, 64'h1);
    @(posedge clk); #1;
    idle_strobes();
    #1;
    check("reissue after data", bus_a.ReadData[0], 64'h78);
    check("reissue after busy", {63'b0, bus_a.Busy[0]}, 64'h1);
    step_a(1'b1, 5'd2, 64'h79, 1'b0, 5'd0);
    check("reissue clear busy", {63'b0, bus_a.Busy[0]}, 64'h0);
    check("reissue clear data", bus_a.ReadData[0], 64'h79);

    // 32-bit, 16-entry, 3-port instance: zero register is 15.
    bus_b.ReadRegister[0] = 4'd15;
    bus_b.ReadRegister[1] = 4'd15;
    bus_b.ReadRegister[2] = 4'd15;
    step_b(1'b1, 4'd15, 32'hDEAD, 1'b0, 4'd0);
    for (int p = 0; p < 3; p++)
      check($sformatf("p3 zero port%0d", p), {32'b0, bus_b.ReadData[p]}, 64'h0);

    step_b(1'b1, 4'd1, 32'h11, 1'b0, 4'd0);
    step_b(1'b1, 4'd2, 32'h22, 1'b0, 4'd0);
    step_b(1'b1, 4'd3, 32'h33, 1'b0, 4'd0);
    bus_b.ReadRegister[0] = 4'd3;
    bus_b.ReadRegister[1] = 4'd1;
    bus_b.ReadRegister[2] = 4'd2;
    #1;
    check("p3 port0 r3", {32'b0, bus_b.ReadData[0]}, 64'h33);
    check("p3 port1 r1", {32'b0, bus_b.ReadData[1]}, 64'h11);
    check("p3 port2 r2", {32'b0, bus_b.ReadData[2]}, 64'h22);

    step_b(1'b0, 4'd0, 32'h0, 1'b1, 4'd15);
    step_b(1'b0, 4'd0, 32'h0, 1'b1, 4'd14);
    bus_b.ReadRegister[0] = 4'd15;
    bus_b.ReadRegister[1] = 4'd14;
    bus_b.ReadRegister[2] = 4'd1;
    #1;
    check("p3 busy r15", {63'b0, bus_b.Busy[0]}, 64'h0);
    check("p3 busy r14", {63'b0, bus_b.Busy[1]}, 64'h1);
    check("p3 busy r1",  {63'b0, bus_b.Busy[2]}, 64'h0);
    check("p3 data r1",  {32'b0, bus_b.ReadData[2]}, 64'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the CPU's 32×64 register file: a configurable-width, configurable-depth register file with NREAD read ports, one write port, a hard-wired zero register and a per-register pending scoreboard. It sits in the decode/writeback boundary of the pipelined CPU. Decode reads operands and sees per-port Busy flags to drive stalls. Writeback writes results and clears the pending state.

## Interface
- DATA_W, 64, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NREAD, 2, number of read ports (1..4)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  reset, synchronous and active-low (sampled on rising clk; 0 = reset)
- RegWrite  input  1  writeback enable
- WriteRegister  input  ADDR_W  writeback index
- WriteData  input  DATA_W  writeback value
- Issue  input  1  mark IssueRegister pending (instruction issued with a destination)
- IssueRegister  input  ADDR_W  destination being issued
- ReadRegister  input  NREAD×ADDR_W  read indices, packed [NREAD-1:0][ADDR_W-1:0]
- ReadData  output  NREAD×DATA_W  read values, packed
- Busy  output  NREAD  1 = the register on that port has an outstanding producer

## Operation
- Zero register ZERO_REG = 2**ADDR_W - 1 (31 at default).
  - Reads return 0.
  - Writes are ignored.
  - An Issue to it is ignored.
  - Busy is always 0.
- Storage: 2**ADDR_W - 1 physical registers. ZERO_REG has no flops.
- Write: if RegWrite and WriteRegister != ZERO_REG, reg[WriteRegister] <= WriteData at the clock edge.
- Pending bit per register, updated at the clock edge:
  - Issue sets pend[IssueRegister].
  - RegWrite clears pend[WriteRegister].
  - Same index, same cycle: set wins. The new producer supersedes the one writing back.
  - Different indices: both updates apply.
  - RegWrite to a register that is not pending is legal. It writes data and the pending bit stays 0.
- Read (combinational, every port independent):
  - ReadData[p] = reg[ReadRegister[p]].
  - Busy[p] = pend[ReadRegister[p]].
  - Bypass rules are in Configuration.
- Multiple ports may read the same index. Each returns identical data.
- Reset: the cycle after reset is sampled low, all registers hold 0 and all pending bits are 0. Writes and Issues in a reset cycle are discarded. While reset is held, ReadData is 0 and Busy is 0 on every port.

## Timing
- Read latency 0 cycles (combinational from ReadRegister, and from WriteData when bypass is compiled in).
- Write latency 1 cycle: a value written at edge N is visible from registered storage after edge N.
- Pending set by Issue at edge N: Busy asserts after edge N.
- Pending clear by RegWrite at edge N: Busy deasserts after edge N, or immediately in the write cycle when bypass is compiled in.
- Reset asserted in the middle of an Issue/writeback sequence aborts it. No partial state survives the reset edge.
- There are no handshakes. The caller holds a stalled instruction until Busy = 0.

## Configuration
- Macro: REGFILE_SB_BYPASS_EN.
- Defined: when RegWrite=1, WriteRegister == ReadRegister[p] and the index != ZERO_REG, then:
  - ReadData[p] = WriteData in the same cycle (write-through).
  - Busy[p] = 0, unless Issue targets the same index in that cycle, in which case Busy[p] = pend of the old state.
- Undefined: reads return pre-edge storage and Busy reflects the registered pend only. Decode must stall one extra cycle.

## Structure
- Package regfile_sb_pkg holds:
  - defaults DATA_W_DEF and ADDR_W_DEF;
  - function zero_reg(ADDR_W);
  - typedef reg_idx_t.
- Sub-module regfile_scoreboard: pending-bit vector, set/clear priority, per-port Busy lookup, reset clear. Bypass override of Busy stays in the top level.
- Storage and read muxes are generated in the top level with a generate loop over NREAD.

## Test plan
- Reset: hold reset=0 for 2 cycles with RegWrite=1, WriteRegister=3, WriteData=0xAA, Issue=1 to reg 4 -> afterwards reg3 reads 0 and Busy for reg4 = 0.
- Write/read: write 0x1234_5678_9ABC_DEF0 to reg 7 -> next cycle both ports reading 7 return that value. Write 0xFF to reg 31 -> reg 31 reads 0.
- Scoreboard: Issue reg 5 at edge N -> Busy=1 for reg 5 after N. RegWrite reg 5 with 0x55 at edge N+3 -> Busy=0 and data=0x55 after N+3.
- Collision: Issue reg 9 and RegWrite reg 9 in the same cycle -> reg 9 = new data and Busy stays 1. Issue reg 31 -> Busy on reg 31 stays 0.
- Bypass (REGFILE_SB_BYPASS_EN defined): pend reg 2, then RegWrite reg 2 = 0x77 while port 0 reads 2 -> same cycle ReadData[0]=0x77 and Busy[0]=0. Without the macro -> old value and Busy[0]=1 that cycle.
- Parametrisation: DATA_W=32, ADDR_W=4, NREAD=3 -> zero register is 15 and all three ports read independently.
